wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-low (0 = reset), sampled on rising clk.
REQ-003 SHALL have ports a_valid in 1, a_rd in 5, a_data in 32  pipeline writeback request (ALU/load result).
REQ-004 SHALL have port a_ready  out  1  A accepted this cycle when a_valid & a_ready.
REQ-005 SHALL have ports b_valid in 1, b_rd in 5, b_data in 32  long-latency unit result return.
REQ-006 SHALL have port b_ready  out  1  B accepted this cycle when b_valid & b_ready.
REQ-007 SHALL have ports issue_valid in 1, issue_rd in 5  long-latency op issued; marks issue_rd pending.
REQ-008 SHALL have ports chk_rs1 in 5, chk_rs2 in 5  decode-stage source register query.
REQ-009 SHALL have port hazard  out  1  combinational: chk_rs1 or chk_rs2 nonzero and pending.
REQ-010 SHALL have ports regWrite out 1, writeReg out 5, writeData out 32  registered drive of the register file write port.
REQ-011 SHALL have port pending  out  31  scoreboard vector, bit i-1 = x[i] pending (i = 1..31).

Function
REQ-012 SHALL accept at most one request (A or B) per cycle; requesters hold valid/rd/data stable until accepted.
REQ-013 SHALL block A (a_ready=0) while a_valid, a_rd != 0 and pending[a_rd] (WAW ordering vs. in-flight B).
REQ-014 SHALL, when only one eligible request, accept it the same cycle (ready=1 combinationally).
REQ-015 SHALL, when A eligible and B valid in the same cycle, grant the side not granted at the last conflict; a last_grant flag updates only on conflict cycles.
REQ-016 SHALL drive regWrite/writeReg/writeData exactly one cycle after acceptance with the accepted rd/data; regWrite=0 in cycles with no acceptance.
REQ-017 SHALL accept requests with rd = 0 normally but keep regWrite=0 for them (write to x0 dropped).
REQ-018 SHALL set pending[issue_rd] on issue_valid with issue_rd != 0; issue to x0 ignored.
REQ-019 SHALL clear pending[b_rd] when B is accepted.
REQ-020 SHALL, on issue and B acceptance to the same rd in one cycle, leave the bit set (set wins).
REQ-021 SHALL compute hazard from the pending vector before the current edge's update (no same-cycle bypass of B data).
REQ-022 SHALL keep writeReg/writeData at their last value when regWrite=0.
REQ-023 SHALL accept B for an rd not pending without error; pending unaffected.

Reset
REQ-024 SHALL, on rising clk with rst=0: regWrite=0, writeReg=0, writeData=0, pending all 0, last_grant=A.
REQ-025 SHALL hold a_ready=0 and b_ready=0 while rst=0; requests present during reset are not accepted and not written.
REQ-026 SHALL discard any in-flight acceptance when reset asserts mid-operation; no write issued in the cycle after reset.

Verification
REQ-027 A only: a_valid, a_rd=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle regWrite=1, writeReg=5, writeData=0xDEADBEEF.
REQ-028 Conflict x3: A (rd=3, 0x11) and B (rd=7, 0x22) valid, held until accepted -> grants alternate B, A, ... starting with B after reset (last_grant=A); one write per cycle, no request lost.
REQ-029 Scoreboard: issue_rd=9; next cycle chk_rs1=9 -> hazard=1; B returns rd=9 accepted -> hazard=0 from next cycle; pending[8] toggles 1 then 0.
REQ-030 WAW: pending x9, a_valid a_rd=9 -> a_ready=0 until B rd=9 accepted; A write follows B write, final writeData = A data.
REQ-031 x0: a_rd=0 a_data=0xFFFFFFFF -> a_ready=1, regWrite stays 0; issue_rd=0 -> pending stays 0.
REQ-032 Reset mid-op: A accepted at cycle N, rst=0 at N+1 -> regWrite=0 at N+1 output, pending cleared, readies 0 until rst=1.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges pipeline (A) and long-latency (B) results onto one
// write port, with a pending-register scoreboard for decode hazards and WAW ordering.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    output logic        hazard,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic [30:0] pending
);

    logic [30:0] r_pending;
    logic        r_last_grant_b;
    logic        r_reg_write;
    logic [4:0]  r_write_reg;
    logic [31:0] r_write_data;

    logic [31:0] w_pend_full;
    logic        w_a_eligible;
    logic        w_conflict;
    logic        w_a_acc;
    logic        w_b_acc;
    logic [4:0]  w_acc_rd;
    logic [31:0] w_acc_data;
    logic [30:0] w_pending_d;

    // Bit 0 stands for x0 and is never pending, so rd == 0 needs no separate test.
    assign w_pend_full  = {r_pending, 1'b0};
    assign w_a_eligible = a_valid && !w_pend_full[a_rd];
    assign w_conflict   = w_a_eligible && b_valid;

    assign a_ready = rst && w_a_eligible && (!b_valid || r_last_grant_b);
    assign b_ready = rst && b_valid && (!w_a_eligible || !r_last_grant_b);
    assign w_a_acc = a_ready;
    assign w_b_acc = b_ready && b_valid;

    assign w_acc_rd   = w_a_acc ? a_rd : b_rd;
    assign w_acc_data = w_a_acc ? a_data : b_data;

    assign hazard = w_pend_full[chk_rs1] || w_pend_full[chk_rs2];

    always_comb begin
        w_pending_d = r_pending;
        if (w_b_acc && b_rd != 5'd0) begin
            w_pending_d[b_rd - 5'd1] = 1'b0;
        end
        // Set after clear so a same-cycle issue to the returning rd stays pending.
        if (issue_valid && issue_rd != 5'd0) begin
            w_pending_d[issue_rd - 5'd1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending      <= '0;
            r_last_grant_b <= 1'b0;
            r_reg_write    <= 1'b0;
            r_write_reg    <= '0;
            r_write_data   <= '0;
        end else begin
            r_pending <= w_pending_d;
            if (w_conflict) begin
                r_last_grant_b <= w_b_acc;
            end
            r_reg_write <= (w_a_acc || w_b_acc) && w_acc_rd != 5'd0;
            if ((w_a_acc || w_b_acc) && w_acc_rd != 5'd0) begin
                r_write_reg  <= w_acc_rd;
                r_write_data <= w_acc_data;
            end
        end
    end

    assign regWrite  = r_reg_write;
    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;
    assign pending   = r_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: reset, single/conflicting requests,
// scoreboard hazards, WAW blocking, x0 handling and mid-operation reset.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        hazard;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [30:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter u_dut (
        .clk         (clk),
        .rst         (rst),
        .a_valid     (a_valid),
        .a_rd        (a_rd),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_rd        (b_rd),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hazard      (hazard),
        .regWrite    (regWrite),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .pending     (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b0; a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
        tick();
        tick();
        check("rst_regWrite", {31'd0, regWrite}, 32'd0);
        check("rst_writeReg", {27'd0, writeReg}, 32'd0);
        check("rst_writeData", writeData, 32'd0);
        check("rst_pending", {1'b0, pending}, 32'd0);
        // Requests during reset are refused and not written.
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h55; b_valid = 1'b1; b_rd = 5'd4;
        settle();
        check("rst_a_ready", {31'd0, a_ready}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        check("rst_no_write", {31'd0, regWrite}, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
        tick();

        // A only
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        settle();
        check("a_only_ready", {31'd0, a_ready}, 32'd1);
        check("a_only_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("a_only_regWrite", {31'd0, regWrite}, 32'd1);
        check("a_only_writeReg", {27'd0, writeReg}, 32'd5);
        check("a_only_writeData", writeData, 32'hDEADBEEF);
        tick();
        check("idle_regWrite", {31'd0, regWrite}, 32'd0);
        check("idle_hold_data", writeData, 32'hDEADBEEF);
        check("idle_hold_reg", {27'd0, writeReg}, 32'd5);

        // Conflict 1: B first since last_grant resets to A
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h22;
        settle();
        check("c1_b_ready", {31'd0, b_ready}, 32'd1);
        check("c1_a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        b_valid = 1'b0;
        check("c1_writeReg", {27'd0, writeReg}, 32'd7);
        check("c1_writeData", writeData, 32'h22);
        settle();
        check("c1_a_ready_after", {31'd0, a_ready}, 32'd1);
        tick();
        check("c1_a_writeReg", {27'd0, writeReg}, 32'd3);
        check("c1_a_writeData", writeData, 32'h11);
        // Conflict 2: A wins
        b_valid = 1'b1;
        settle();
        check("c2_a_ready", {31'd0, a_ready}, 32'd1);
        check("c2_b_ready", {31'd0, b_ready}, 32'd0);
        tick();
        a_valid = 1'b0;
        check("c2_writeReg", {27'd0, writeReg}, 32'd3);
        settle();
        check("c2_b_ready_after", {31'd0, b_ready}, 32'd1);
        tick();
        check("c2_b_writeReg", {27'd0, writeReg}, 32'd7);
        check("c2_b_regWrite", {31'd0, regWrite}, 32'd1);
        // Conflict 3: B wins again
        a_valid = 1'b1;
        settle();
        check("c3_b_ready", {31'd0, b_ready}, 32'd1);
        check("c3_a_ready", {31'd0, a_ready}, 32'd0);
        tick();
        b_valid = 1'b0;
        tick();
        a_valid = 1'b0;
        check("c3_a_writeReg", {27'd0, writeReg}, 32'd3);
        tick();

        // Scoreboard and WAW
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        check("sb_pending_set", {1'b0, pending}, 32'h100);
        chk_rs1 = 5'd9;
        settle();
        check("sb_hazard_rs1", {31'd0, hazard}, 32'd1);
        chk_rs1 = 5'd0; chk_rs2 = 5'd9;
        settle();
        check("sb_hazard_rs2", {31'd0, hazard}, 32'd1);
        chk_rs2 = 5'd10;
        settle();
        check("sb_no_hazard", {31'd0, hazard}, 32'd0);
        chk_rs1 = 5'd9;
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'hAAAA5555;
        settle();
        check("waw_a_blocked", {31'd0, a_ready}, 32'd0);
        tick();
        check("waw_no_write", {31'd0, regWrite}, 32'd0);
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h12345678;
        settle();
        check("waw_b_ready", {31'd0, b_ready}, 32'd1);
        check("waw_a_still_blocked", {31'd0, a_ready}, 32'd0);
        check("waw_hazard_pre", {31'd0, hazard}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("waw_b_writeData", writeData, 32'h12345678);
        check("waw_pending_clr", {1'b0, pending}, 32'd0);
        settle();
        check("waw_hazard_clr", {31'd0, hazard}, 32'd0);
        check("waw_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0;
        check("waw_a_writeReg", {27'd0, writeReg}, 32'd9);
        check("waw_a_writeData", writeData, 32'hAAAA5555);
        chk_rs1 = 5'd0; chk_rs2 = 5'd0;

        // Issue and return to same rd in one cycle: set wins
        issue_valid = 1'b1; issue_rd = 5'd12;
        tick();
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'hC0C0;
        tick();
        issue_valid = 1'b0;
        check("same_rd_set_wins", {1'b0, pending}, 32'h800);
        tick();
        b_valid = 1'b0;
        check("same_rd_cleared", {1'b0, pending}, 32'd0);
        // B for a non-pending rd
        b_valid = 1'b1; b_rd = 5'd20; b_data = 32'h2020;
        settle();
        check("b_unpend_ready", {31'd0, b_ready}, 32'd1);
        tick();
        b_valid = 1'b0;
        check("b_unpend_writeReg", {27'd0, writeReg}, 32'd20);
        check("b_unpend_pending", {1'b0, pending}, 32'd0);

        // x0 handling
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFFFFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        settle();
        check("x0_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        a_valid = 1'b0; issue_valid = 1'b0;
        check("x0_regWrite", {31'd0, regWrite}, 32'd0);
        check("x0_hold_data", writeData, 32'h2020);
        check("x0_pending", {1'b0, pending}, 32'd0);
        settle();
        check("x0_hazard", {31'd0, hazard}, 32'd0);

        // Reset mid-operation
        a_valid = 1'b1; a_rd = 5'd6; a_data = 32'h66;
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0;
        check("mid_regWrite_pre", {31'd0, regWrite}, 32'd1);
        check("mid_pending_pre", {1'b0, pending}, 32'h8);
        rst = 1'b0;
        settle();
        check("mid_a_ready_rst", {31'd0, a_ready}, 32'd0);
        tick();
        check("mid_regWrite_rst", {31'd0, regWrite}, 32'd0);
        check("mid_pending_rst", {1'b0, pending}, 32'd0);
        check("mid_writeData_rst", writeData, 32'd0);
        tick();
        check("mid_regWrite_hold", {31'd0, regWrite}, 32'd0);
        a_valid = 1'b0; rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
